// File: rtl/change_disp_pkg.sv
// Shared types and constants for the change dispenser.
// Coin values are counted in Rs.5 units.
package change_disp_pkg;

    typedef enum logic [1:0] {
        CHNG_NONE = 2'b00,
        CHNG_5    = 2'b01,
        CHNG_10   = 2'b10,
        CHNG_15   = 2'b11
    } chng_code_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRD_DROP,
        ST_COIN_SEL,
        ST_COIN_PULSE,
        ST_COIN_WAIT,
        ST_DONE,
        ST_FAULT
    } disp_state_t;

    localparam logic [2:0] PRD_NONE = 3'b000;
    localparam logic [1:0] COIN5    = 2'd1;
    localparam logic [1:0] COIN10   = 2'd2;

    typedef struct packed {
        logic [2:0] prd;
        logic [1:0] rem;
    } vend_t;

    function automatic logic [1:0] sat_add2(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[2] ? 2'd3 : s[1:0];
    endfunction

endpackage

// File: rtl/change_dispenser_eject_timer.sv
// Per-coin eject pulse width counter plus ack-timeout counter.
// Latency: pulse_on rises the cycle after start; timed_out in cycle ACK_TIMEOUT of the pulse.
// Backpressure: none; ack or timeout stops both counters until the next start.
module eject_timer #(
    parameter int PULSE_W     = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ack,
    output logic pulse_on,
    output logic timed_out
);
    localparam logic [7:0] PW  = 8'(PULSE_W);
    localparam logic [7:0] TMO = 8'(ACK_TIMEOUT);

    logic [7:0] cnt_q, cnt_d;
    logic       act_q, act_d;
    logic       pulse_q, pulse_d;

    assign timed_out = act_q && (cnt_q == TMO);
    assign pulse_on  = pulse_q;

    // cnt_q holds the 1-based cycle index of the current pulse/wait window
    always_comb begin
        cnt_d   = cnt_q;
        act_d   = act_q;
        pulse_d = pulse_q;
        if (start) begin
            act_d   = 1'b1;
            pulse_d = 1'b1;
            cnt_d   = 8'd1;
        end else if (ack || timed_out) begin
            act_d   = 1'b0;
            pulse_d = 1'b0;
        end else if (act_q) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == PW) begin
                pulse_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            act_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            pulse_q <= pulse_d;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Turns one vend result into a timed product drop then handshaked coin ejects (HOPPER_FALLBACK_EN: pay 5s when Rs.10 hopper empty).
// Latency: done in cycle PRD_TIME+1 after the vend_vld cycle for product-only vends.
// Backpressure: vend_vld is dropped while busy; a missing coin_ack ends in sticky fault until fault_clr.
module change_dispenser
    import change_disp_pkg::*;
#(
    parameter int PRD_TIME    = 4,
    parameter int PULSE_W     = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vend_vld,
    input  logic [2:0] prd_in,
    input  logic [1:0] chng_in,
    input  logic       coin_ack,
    input  logic       empty10,
    input  logic       fault_clr,
    output logic [2:0] prd_motor,
    output logic       eject5,
    output logic       eject10,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [1:0] paid_amt
);
    localparam logic [3:0] DROP_LAST = 4'(PRD_TIME);

    disp_state_t state_q, state_d;
    vend_t       vend_q, vend_d;
    logic [1:0]  paid_q, paid_d;
    logic        coin10_q, coin10_d;
    logic [3:0]  drop_cnt_q, drop_cnt_d;

    logic tmr_start, ack_ok, pulse_on, timed_out, use10;

    assign tmr_start = (state_q == ST_COIN_SEL);
    assign ack_ok    = coin_ack && ((state_q == ST_COIN_PULSE) || (state_q == ST_COIN_WAIT));

`ifdef HOPPER_FALLBACK_EN
    assign use10 = (vend_q.rem >= COIN10) && !empty10;
`else
    logic unused_empty10;
    assign unused_empty10 = empty10;
    assign use10          = (vend_q.rem >= COIN10);
`endif

    eject_timer #(
        .PULSE_W     (PULSE_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_eject_timer (
        .clk       (clk),
        .rst       (rst),
        .start     (tmr_start),
        .ack       (ack_ok),
        .pulse_on  (pulse_on),
        .timed_out (timed_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (vend_vld) begin
                    if (prd_in != PRD_NONE)                     state_d = ST_PRD_DROP;
                    else if (chng_code_t'(chng_in) != CHNG_NONE) state_d = ST_COIN_SEL;
                    else                                        state_d = ST_DONE;
                end
            end
            ST_PRD_DROP: begin
                if (drop_cnt_q == DROP_LAST) begin
                    state_d = (vend_q.rem != 2'd0) ? ST_COIN_SEL : ST_DONE;
                end
            end
            ST_COIN_SEL: state_d = ST_COIN_PULSE;
            ST_COIN_PULSE: begin
                if (ack_ok)         state_d = (vend_q.rem != 2'd0) ? ST_COIN_SEL : ST_DONE;
                else if (timed_out) state_d = ST_FAULT;
                else if (!pulse_on) state_d = ST_COIN_WAIT;
            end
            ST_COIN_WAIT: begin
                if (ack_ok)         state_d = (vend_q.rem != 2'd0) ? ST_COIN_SEL : ST_DONE;
                else if (timed_out) state_d = ST_FAULT;
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: if (fault_clr) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // vend_q.rem is already decremented by COIN_SEL, so it is what remains after the coin in flight
    always_comb begin
        vend_d     = vend_q;
        paid_d     = paid_q;
        coin10_d   = coin10_q;
        drop_cnt_d = drop_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (vend_vld) begin
                    vend_d.prd = prd_in;
                    vend_d.rem = chng_in;
                    paid_d     = 2'd0;
                    drop_cnt_d = 4'd1;
                end
            end
            ST_PRD_DROP: drop_cnt_d = drop_cnt_q + 4'd1;
            ST_COIN_SEL: begin
                coin10_d   = use10;
                vend_d.rem = vend_q.rem - (use10 ? COIN10 : COIN5);
            end
            ST_COIN_PULSE, ST_COIN_WAIT: begin
                if (ack_ok) begin
                    paid_d = sat_add2(paid_q, coin10_q ? COIN10 : COIN5);
                end
            end
            ST_FAULT: if (fault_clr) vend_d.rem = 2'd0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vend_q     <= '0;
            paid_q     <= 2'd0;
            coin10_q   <= 1'b0;
            drop_cnt_q <= 4'd0;
        end else begin
            vend_q     <= vend_d;
            paid_q     <= paid_d;
            coin10_q   <= coin10_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        prd_motor = (state_q == ST_PRD_DROP) ? vend_q.prd : PRD_NONE;
        eject5    = (state_q == ST_COIN_PULSE) && pulse_on && !coin10_q;
        eject10   = (state_q == ST_COIN_PULSE) && pulse_on && coin10_q;
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        fault     = (state_q == ST_FAULT);
        paid_amt  = paid_q;
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Vector table plus scoreboard for change_dispenser; a responder answers eject pulses with coin_ack.
module tb_change_dispenser;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vend_vld = 1'b0;
    logic [2:0] prd_in = 3'd0;
    logic [1:0] chng_in = 2'd0;
    logic       coin_ack = 1'b0;
    logic       empty10 = 1'b0;
    logic       fault_clr = 1'b0;
    logic [2:0] prd_motor;
    logic       eject5, eject10, busy, done, fault;
    logic [1:0] paid_amt;

    always #5 clk = ~clk;

    change_dispenser #(.PRD_TIME(4), .PULSE_W(2), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .vend_vld(vend_vld), .prd_in(prd_in), .chng_in(chng_in),
        .coin_ack(coin_ack), .empty10(empty10), .fault_clr(fault_clr),
        .prd_motor(prd_motor), .eject5(eject5), .eject10(eject10), .busy(busy),
        .done(done), .fault(fault), .paid_amt(paid_amt)
    );

    typedef struct {
        logic [2:0] prd;
        logic [1:0] chng;
        logic       emp;
        int         dly;      // cycles from eject rise to coin_ack; 255 = never
        int         strobe;   // cycle at which to strobe a stray vend_vld; 0 = never
        bit         exp_done; // 1 = done, 0 = fault
        int         lat, mot, n5, n10, w, paid;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vidx = 0;

    function automatic vec_t mk(input logic [2:0] prd, input logic [1:0] chng, input logic emp,
                                input int dly, input int strobe, input bit exp_done, input int lat,
                                input int mot, input int n5, input int n10, input int w, input int paid);
        vec_t v;
        v.prd = prd; v.chng = chng; v.emp = emp; v.dly = dly; v.strobe = strobe;
        v.exp_done = exp_done; v.lat = lat; v.mot = mot; v.n5 = n5; v.n10 = n10; v.w = w; v.paid = paid;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (vec %0d): actual %0d required %0d", name, vidx, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   cyc, mot_cnt, mot_bad, n5, n10, wcur, wmax, k, lat, paid;
        bit   finished, pend, p5, p10, got_done;
        vec_t e;
        cyc = 0; mot_cnt = 0; mot_bad = 0; n5 = 0; n10 = 0; wcur = 0; wmax = 0; k = 0;
        lat = 0; paid = 0; finished = 0; pend = 0; p5 = 0; p10 = 0; got_done = 0;
        exp_q.push_back(v);
        prd_in = v.prd; chng_in = v.chng; empty10 = v.emp; vend_vld = 1'b1;
        while (!finished && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            vend_vld = 1'b0; prd_in = 3'd0; chng_in = 2'd0; coin_ack = 1'b0;
            if (prd_motor != 3'd0) begin
                mot_cnt++;
                if (prd_motor != v.prd) mot_bad++;
            end
            if (eject5 && !p5) n5++;
            if (eject10 && !p10) n10++;
            if (eject5 || eject10) begin
                wcur++;
                if (wcur > wmax) wmax = wcur;
                if (!(p5 || p10)) begin pend = 1; k = 0; end
            end else begin
                wcur = 0;
            end
            if (pend) begin
                if (k == v.dly) begin coin_ack = 1'b1; pend = 0; end
                k++;
            end
            p5 = eject5; p10 = eject10;
            if (done || fault) begin
                finished = 1; lat = cyc; got_done = done; paid = int'(paid_amt);
            end else if (cyc == v.strobe) begin
                vend_vld = 1'b1; prd_in = 3'd6; chng_in = 2'd3;
            end
        end
        coin_ack = 1'b0;
        chk("completion_within_budget", int'(finished), 1);
        if (exp_q.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk("end_is_done", int'(got_done), int'(e.exp_done));
            chk("latency", lat, e.lat);
            chk("motor_cycles", mot_cnt, e.mot);
            chk("motor_code_errs", mot_bad, 0);
            chk("eject5_pulses", n5, e.n5);
            chk("eject10_pulses", n10, e.n10);
            chk("pulse_width", wmax, e.w);
            chk("paid_amt", paid, e.paid);
        end
        if (finished && got_done) begin
            @(posedge clk); #1;
            chk("done_one_cycle", int'(done), 0);
            chk("busy_after_done", int'(busy), 0);
        end else if (finished) begin
            chk("fault_busy", int'(busy), 1);
            vend_vld = 1'b1; prd_in = 3'd1; chng_in = 2'd1;
            @(posedge clk); #1;
            vend_vld = 1'b0; prd_in = 3'd0; chng_in = 2'd0;
            chk("fault_ignores_vend", int'(fault), 1);
            chk("fault_paid_hold", int'(paid_amt), v.paid);
            chk("fault_quiet_motor", int'(prd_motor), 0);
            fault_clr = 1'b1;
            @(posedge clk); #1;
            fault_clr = 1'b0;
            chk("fault_cleared", int'(fault), 0);
            chk("busy_after_clr", int'(busy), 0);
        end
        empty10 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        bit seen;
        vecs.push_back(mk(3'd3, 2'd1, 1'b0,   3, 2, 1, 10, 4, 1, 0, 2, 1));
        vecs.push_back(mk(3'd3, 2'd3, 1'b0,   0, 0, 1,  9, 4, 1, 1, 1, 3));
        vecs.push_back(mk(3'd0, 2'd0, 1'b0,   0, 0, 1,  1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(3'd0, 2'd2, 1'b0, 255, 0, 0, 18, 0, 0, 1, 2, 0));
        vecs.push_back(mk(3'd5, 2'd0, 1'b0,   0, 0, 1,  5, 4, 0, 0, 0, 0));
        vecs.push_back(mk(3'd0, 2'd1, 1'b0,   5, 0, 1,  8, 0, 1, 0, 2, 1));
        vecs.push_back(mk(3'd7, 2'd2, 1'b0,   1, 0, 1,  8, 4, 0, 1, 2, 2));
        vecs.push_back(mk(3'd0, 2'd3, 1'b0,  14, 0, 1, 33, 0, 1, 1, 2, 3));
`ifdef HOPPER_FALLBACK_EN
        vecs.push_back(mk(3'd0, 2'd3, 1'b1,   0, 0, 1,  7, 0, 3, 0, 1, 3));
`else
        vecs.push_back(mk(3'd0, 2'd3, 1'b1,   0, 0, 1,  5, 0, 1, 1, 1, 3));
`endif
        vecs.push_back(mk(3'd2, 2'd1, 1'b0, 255, 0, 0, 22, 4, 1, 0, 2, 0));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_motor", int'(prd_motor), 0);
        chk("rst_ejects", int'({eject5, eject10}), 0);
        chk("rst_paid", int'(paid_amt), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            vidx = i;
            run_vec(vecs[i]);
        end

        // reset while an eject pulse is on the wire
        vidx = 100;
        prd_in = 3'd0; chng_in = 2'd2; vend_vld = 1'b1;
        @(posedge clk); #1;
        vend_vld = 1'b0; chng_in = 2'd0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (eject10) seen = 1;
            else begin @(posedge clk); #1; end
        end
        chk("midpulse_reached", int'(seen), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_eject10", int'(eject10), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_outputs", int'({prd_motor, eject5, done, fault, paid_amt}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle", int'(busy), 0);
        chk("post_rst_no_pulse", int'(eject10), 0);

        vidx = 101;
        coin_ack = 1'b1;
        @(posedge clk); #1;
        coin_ack = 1'b0;
        chk("idle_ack_busy", int'(busy), 0);
        chk("idle_ack_paid", int'(paid_amt), 0);
        run_vec(mk(3'd0, 2'd1, 1'b0, 0, 0, 1, 3, 0, 1, 0, 1, 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Output-side companion to vending_machine: consumes its product code (prd) and change code (chng) and drives the physical product motor and two coin hoppers (Rs.5, Rs.10).
- Converts one vend result into a timed product-drop phase, then a sequence of handshaked coin-eject pulses.
- Reports completion, or a sticky fault if a hopper fails to acknowledge a coin.

Parameters:
- PRD_TIME, 4, cycles prd_motor is held with the product code (1..15).
- PULSE_W, 2, cycles each eject pulse stays high (1..7).
- ACK_TIMEOUT, 16, cycles allowed from eject-pulse start to coin_ack before fault (> PULSE_W, ≤ 255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- vend_vld  input  1  one-cycle strobe: prd_in/chng_in valid.
- prd_in  input  3  product code; 3'b000 = no product.
- chng_in  input  2  change code: 00 none, 01 Rs.5, 10 Rs.10, 11 Rs.15.
- coin_ack  input  1  hopper sensor pulse, one coin fell (either hopper).
- empty10  input  1  Rs.10 hopper empty; used only with the optional feature.
- fault_clr  input  1  clears FAULT.
- prd_motor  output  3  product code during drop, else 0.
- eject5  output  1  Rs.5 hopper eject pulse.
- eject10  output  1  Rs.10 hopper eject pulse.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse on successful completion.
- fault  output  1  high while in FAULT.
- paid_amt  output  2  change paid so far, in Rs.5 units; valid with done/fault.

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; rem = 0. Reset mid-operation aborts; pulses drop at once.
- States: IDLE, PRD_DROP, COIN_SEL, COIN_PULSE, COIN_WAIT, DONE, FAULT.
- IDLE: when vend_vld = 1, latch prd_in and rem = chng_in (Rs.5 units 0..3); clear paid_amt.
  - prd_in != 0: go to PRD_DROP.
  - prd_in = 0 and rem != 0: go to COIN_SEL.
  - Both zero: go to DONE.
- vend_vld while busy is ignored; no queuing.
- PRD_DROP: prd_motor = latched code for exactly PRD_TIME cycles. Then COIN_SEL if rem != 0, else DONE.
- COIN_SEL (1 cycle): greedy coin choice.
  - rem ≥ 2: select Rs.10; rem -= 2.
  - Otherwise: select Rs.5; rem -= 1.
  - Order for Rs.15 is 10 then 5.
- COIN_PULSE: selected eject line high for PULSE_W cycles. Timeout counter starts at the first pulse cycle.
- COIN_WAIT: waits for coin_ack.
  - coin_ack in COIN_PULSE or COIN_WAIT: paid_amt += coin value; pulse ends early if still running.
  - After ack: COIN_SEL if rem != 0, else DONE.
- Timeout: counter reaches ACK_TIMEOUT with no ack → FAULT; eject lines low.
- Ack timing: coin_ack outside COIN_PULSE/COIN_WAIT is ignored. Multiple acks count once per coin.
- DONE (1 cycle): done = 1, busy = 1, then IDLE. busy falls the cycle after done.
- FAULT: fault = 1, busy = 1, outputs otherwise quiescent; paid_amt holds.
  - fault_clr = 1 → IDLE; residual rem discarded.
  - vend_vld is ignored in FAULT.
- Simultaneous rst with any input: rst wins.
- Width rules: paid_amt saturates at 3 and never wraps. Timeout counter is 8 bits.
- Minimum latency, prd != 0 and chng = 00: done asserts PRD_TIME + 1 cycles after the vend_vld edge.

Optional Feature:
- Macro: HOPPER_FALLBACK_EN.
- Defined: in COIN_SEL, if rem ≥ 2 and empty10 = 1, select Rs.5 instead; Rs.15 with empty Rs.10 hopper pays 5+5+5.
- Undefined: empty10 is ignored (no logic); greedy selection only.

Decomposition:
- Package change_disp_pkg holds:
  - chng_code_t enum (CHNG_NONE, CHNG_5, CHNG_10, CHNG_15).
  - disp_state_t enum.
  - PRD_NONE = 3'b000.
  - Coin-unit constants (COIN5 = 1, COIN10 = 2).
- Sub-module eject_timer: per-coin pulse-width counter plus ack-timeout counter.
  - Inputs: start, ack.
  - Outputs: pulse_on, timed_out.
  - Instantiated once.

Test Plan:
- prd_in = 3'b011, chng_in = 01, ack 3 cycles after eject5 rises → prd_motor = 011 for 4 cycles; one eject5 pulse of 2 cycles; done with paid_amt = 1.
- prd_in = 3'b011, chng_in = 11, prompt acks → eject10 pulse, then eject5 pulse; done with paid_amt = 3.
- prd_in = 0, chng_in = 00 → done exactly one cycle after acceptance; no motor or eject activity.
- chng_in = 10, no coin_ack → fault rises 16 cycles after eject10 rises; paid_amt = 0. fault_clr → IDLE; busy = 0.
- HOPPER_FALLBACK_EN, empty10 = 1, chng_in = 11 → three eject5 pulses, eject10 never high; paid_amt = 3.
- rst asserted mid-COIN_PULSE, plus vend_vld strobed while busy → outputs zero immediately on rst; the vend_vld strobe while busy leaves the latched transaction unchanged.
